// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-segmented adder.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

endpackage

// File: rtl/adder_chunk.sv
// One carry-chain segment: a W-bit combinational ripple-carry adder.
module adder_chunk #(
    parameter int W = 8
) (
    output logic [W-1:0] sum,
    output logic         cout,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    input  logic         cin
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = num1[i] ^ num2[i] ^ c;
            c      = (num1[i] & num2[i]) | (c & (num1[i] ^ num2[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CHUNK-bit carry segment per register stage,
// with unconsumed operand bits and finished sum bits skewed through the stages.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;

    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic             is_sub;
    logic             cin_eff;
    logic [WIDTH-1:0] b_eff;
    logic             advance;

    assign is_sub   = (op_e'(sub) == OP_SUB);
    assign b_eff    = is_sub ? ~num2 : num2;
    assign cin_eff  = is_sub ? 1'b1 : cin;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits still to be added when entering stage k, rebased to bit 0.
        localparam int AW = WIDTH - k * CHUNK;

        logic                   vld_p;
        logic                   c_p;
        logic                   am_p;
        logic                   bm_p;
        logic [(k+1)*CHUNK-1:0] s_p;

        logic [AW-1:0]          a_src;
        logic [AW-1:0]          b_src;
        logic                   ci;
        logic                   vld_in;
        logic                   am_in;
        logic                   bm_in;
        logic [CHUNK-1:0]       cs;
        logic                   co;
        logic [(k+1)*CHUNK-1:0] s_nxt;

        if (k == 0) begin : g_head
            assign a_src  = num1;
            assign b_src  = b_eff;
            assign ci     = cin_eff;
            assign vld_in = in_valid;
            assign am_in  = num1[MSB];
            assign bm_in  = b_eff[MSB];
            assign s_nxt  = cs;
        end else begin : g_body
            assign a_src  = g_st[k-1].g_opnd.a_p;
            assign b_src  = g_st[k-1].g_opnd.b_p;
            assign ci     = g_st[k-1].c_p;
            assign vld_in = g_st[k-1].vld_p;
            assign am_in  = g_st[k-1].am_p;
            assign bm_in  = g_st[k-1].bm_p;
            assign s_nxt  = {cs, g_st[k-1].s_p};
        end

        adder_chunk #(
            .W(CHUNK)
        ) u_chunk (
            .sum  (cs),
            .cout (co),
            .num1 (a_src[CHUNK-1:0]),
            .num2 (b_src[CHUNK-1:0]),
            .cin  (ci)
        );

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
                c_p   <= 1'b0;
                am_p  <= 1'b0;
                bm_p  <= 1'b0;
                s_p   <= '0;
            end else if (advance) begin
                vld_p <= vld_in;
                c_p   <= co;
                am_p  <= am_in;
                bm_p  <= bm_in;
                s_p   <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_opnd
            logic [AW-CHUNK-1:0] a_p;
            logic [AW-CHUNK-1:0] b_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_p <= '0;
                    b_p <= '0;
                end else if (advance) begin
                    a_p <= a_src[AW-1:CHUNK];
                    b_p <= b_src[AW-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_p;
    assign sum       = g_st[STAGES-1].s_p;
    assign cout      = g_st[STAGES-1].c_p;
    assign ovf       = ovf_f(g_st[STAGES-1].am_p, g_st[STAGES-1].bm_p, sum[MSB]);
    assign zero      = (sum == '0);

endmodule
